// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : Exception/ERET sequencer: writes EPC, flushes the pipeline for a
//            fixed window, then redirects fetch over a valid/ready handshake.
//            Optional trigger statistics when EXC_CTRL_STAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
  parameter logic [4:0]  EPC_ADDR     = 5'd14
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  output logic        cp0_ex,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic [4:0]  cp0_raddr,
  input  logic [31:0] cp0_rdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
`ifdef EXC_CTRL_STAT_EN
  output logic [31:0] exc_count,
  output logic [31:0] eret_count,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0]  C_CNT_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] C_SAT_MAX  = 32'hffffffff;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_target;
  logic [31:0] w_target_nxt;
  logic        w_trig;
  logic        w_trig_ex;
  logic        w_trig_eret;
  logic [31:0] w_epc;

  assign cp0_raddr = EPC_ADDR;
  assign cp0_waddr = EPC_ADDR;
  assign busy      = (r_state != S_IDLE);

  // ws_ex wins over ws_eret when both are raised by the same instruction
  assign w_trig      = (r_state == S_IDLE) & ws_valid & (ws_ex | ws_eret);
  assign w_trig_ex   = w_trig & ws_ex;
  assign w_trig_eret = w_trig & ~ws_ex & ws_eret;
  assign w_epc       = ws_bd ? (ws_pc - 32'd4) : ws_pc;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_nxt  = S_FLUSH;
          w_cnt_nxt    = C_CNT_LOAD;
          w_target_nxt = ws_ex ? EXC_VECTOR : cp0_rdata;
        end
      end
      S_FLUSH: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_REDIRECT;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_target <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_target <= w_target_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cp0_ex         <= 1'b0;
      cp0_wdata      <= 32'd0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      cp0_ex         <= w_trig_ex;
      flush          <= (w_state_nxt != S_IDLE);
      redirect_valid <= (w_state_nxt == S_REDIRECT);
      if (w_trig_ex) begin
        cp0_wdata <= w_epc;
      end
      if ((w_state_nxt == S_REDIRECT) && (r_state != S_REDIRECT)) begin
        redirect_pc <= r_target;
      end
    end
  end

`ifdef EXC_CTRL_STAT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_count  <= 32'd0;
      eret_count <= 32'd0;
    end else begin
      if (w_trig_ex && (exc_count != C_SAT_MAX)) begin
        exc_count <= exc_count + 32'd1;
      end
      if (w_trig_eret && (eret_count != C_SAT_MAX)) begin
        eret_count <= eret_count + 32'd1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = w_trig_eret ^ (C_SAT_MAX == 32'd0);
`endif

endmodule
`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Pipeline-side exception/ERET sequencer that drives the CP0 register block's write port and ex strobe, and reads EPC through its read port.
- Sits between the writeback stage and CP0/fetch. Detects a committing exception or ERET, flushes the pipeline for a fixed window, then redirects fetch with a valid/ready handshake.

Parameters:
- FLUSH_CYCLES, 2, number of cycles spent in FLUSH state (legal 1..15).
- EXC_VECTOR, 32'hbfc00380, fetch target for any exception.
- EPC_ADDR, 5'd14, CP0 register number of EPC.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- ws_valid  in  1  writeback stage holds a valid instruction
- ws_ex  in  1  instruction raised an exception
- ws_eret  in  1  instruction is ERET
- ws_bd  in  1  instruction is in a branch delay slot
- ws_pc  in  32  instruction PC
- cp0_ex  out  1  CP0 ex strobe (EPC write enable)
- cp0_waddr  out  5  CP0 write address
- cp0_wdata  out  32  CP0 write data (EPC value)
- cp0_raddr  out  5  CP0 read address
- cp0_rdata  in  32  CP0 read data (combinational from raddr)
- flush  out  1  pipeline flush, all stages
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepts redirect
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE; cp0_ex=0; cp0_waddr=EPC_ADDR; cp0_wdata=0; flush=0; redirect_valid=0; redirect_pc=0; counter=0.
- cp0_raddr is the constant EPC_ADDR. cp0_waddr is the constant EPC_ADDR.
- Trigger condition: trig = (state==IDLE) & ws_valid & (ws_ex | ws_eret). Triggers are evaluated only in IDLE; ws_* inputs are ignored in FLUSH and REDIRECT.
- ws_ex has priority over ws_eret when both are high; the event is treated as an exception only.
- Exception trigger cycle T, registered so visible at T+1:
  - cp0_ex=1 for exactly one cycle (T+1).
  - cp0_wdata = ws_bd ? ws_pc-32'd4 : ws_pc, modulo 2^32 (0x00000000-4 = 0xfffffffc).
  - target = EXC_VECTOR.
- ERET trigger cycle T: cp0_rdata is sampled at T; target = cp0_rdata; cp0_ex stays 0.
- State machine:
  - IDLE -> FLUSH on trig; counter loaded with FLUSH_CYCLES-1.
  - FLUSH: flush=1; counter decrements each cycle; -> REDIRECT when counter==0.
  - REDIRECT: flush=1; redirect_valid=1; redirect_pc=target. Both are held stable until redirect_ready=1. On a valid&ready cycle -> IDLE, and redirect_valid and flush drop the next cycle.
- flush rises at T+1 and stays high through the last REDIRECT cycle.
- Minimum busy time with ready held high: FLUSH_CYCLES+1 cycles.
- redirect_ready while redirect_valid=0 has no effect.
- Back-to-back: a new trigger is accepted on the first cycle after returning to IDLE.
- resetn asserted mid-FLUSH or mid-REDIRECT: immediate return to reset values; the pending redirect is discarded.

Optional Feature:
- Macro: EXC_CTRL_STAT_EN.
- Defined:
  - Adds output exc_count[31:0] and output eret_count[31:0], both reset to 0.
  - Each increments by 1 on an exception or ERET trigger respectively and saturates at 32'hffffffff.
  - A simultaneous ex+eret trigger counts only in exc_count.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Exception, no BD: ws_valid=1, ws_ex=1, ws_pc=0xbfc00100 at T, ready=1 -> cp0_ex=1 at T+1 only; cp0_wdata=0xbfc00100; flush high T+1..T+3; redirect_valid=1, redirect_pc=0xbfc00380 at T+3; busy low at T+4.
- Exception in BD slot: ws_pc=0x80000004, ws_bd=1 -> cp0_wdata=0x80000000. With ws_pc=0x0, ws_bd=1 -> cp0_wdata=0xfffffffc.
- ERET: cp0_rdata=0x80001234, ws_eret=1 at T -> cp0_ex never asserts; redirect_pc=0x80001234; cp0_rdata changed after T has no effect on redirect_pc.
- Handshake stall: redirect_ready=0 for 5 cycles in REDIRECT -> redirect_valid, redirect_pc and flush stable; a new ws_ex pulse is ignored; IDLE one cycle after ready=1.
- Priority and reset: ws_ex=1 and ws_eret=1 together -> redirect_pc=EXC_VECTOR and cp0_ex pulses. resetn=0 during FLUSH -> flush=0 and redirect_valid=0 immediately, state IDLE.
- With EXC_CTRL_STAT_EN: 3 exceptions and 2 ERETs -> exc_count=3 and eret_count=2. Without the macro, the bench compiles with no count ports.
